// File: rtl/side_buffer_pkg.sv
// Shared types and defaults for the MinBD side buffer.
// Optional round-robin slot select is enabled with SIDEBUF_ROTATE_EN.
package side_buffer_pkg;

    localparam int SIDEBUF_DEPTH     = 4;
    localparam int SIDEBUF_STARVE_TH = 2;
    localparam int N_CHNL            = 4;

    typedef struct packed {
        logic        vld;
        logic [3:0]  dst;
        logic [15:0] data;
    } flit_int_t;

    function automatic logic [3:0] chnl_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/side_buffer_if.sv
// Channel bundle between the redirect stage and the side buffer.
// The router side is the master; the side buffer is the slave.
interface side_buffer_if;
    import side_buffer_pkg::*;

    flit_int_t din_0;
    flit_int_t din_1;
    flit_int_t din_2;
    flit_int_t din_3;
    flit_int_t din_redirected;
    logic      redirect_gnt;
    flit_int_t dout_0;
    flit_int_t dout_1;
    flit_int_t dout_2;
    flit_int_t dout_3;
    logic      full;
    logic      starve;

    modport master (
        output din_0, din_1, din_2, din_3,
        output din_redirected, redirect_gnt,
        input  dout_0, dout_1, dout_2, dout_3,
        input  full, starve
    );

    modport slave (
        input  din_0, din_1, din_2, din_3,
        input  din_redirected, redirect_gnt,
        output dout_0, dout_1, dout_2, dout_3,
        output full, starve
    );

endinterface

// File: rtl/side_buffer_insert_one_flit.sv
// Places one flit into the channel selected by a one-hot vector.
// Counterpart of the redirect stage's flit-removal block.
module insert_one_flit
    import side_buffer_pkg::*;
(
    input  flit_int_t  din_0,
    input  flit_int_t  din_1,
    input  flit_int_t  din_2,
    input  flit_int_t  din_3,
    input  flit_int_t  ins_flit,
    input  logic [3:0] chnl_vec,
    output flit_int_t  dout_0,
    output flit_int_t  dout_1,
    output flit_int_t  dout_2,
    output flit_int_t  dout_3
);

    assign dout_0 = chnl_vec[0] ? ins_flit : din_0;
    assign dout_1 = chnl_vec[1] ? ins_flit : din_1;
    assign dout_2 = chnl_vec[2] ? ins_flit : din_2;
    assign dout_3 = chnl_vec[3] ? ins_flit : din_3;

endmodule

// File: rtl/side_buffer.sv
// MinBD side buffer: holds redirected flits and reinjects them into free slots.
// Define SIDEBUF_ROTATE_EN for round-robin slot select instead of lowest-index.
module side_buffer
    import side_buffer_pkg::*;
#(
    parameter int DEPTH     = SIDEBUF_DEPTH,
    parameter int STARVE_TH = SIDEBUF_STARVE_TH
) (
    input  logic        clk,
    input  logic        reset,
    side_buffer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [7:0]    TH       = 8'(STARVE_TH);

    flit_int_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic [7:0]      stv_cnt;
    logic [7:0]      stv_cnt_n;
    logic            full_q;
    logic            starve_q;
    logic [3:0]      empty_vec;
    logic [3:0]      chnl_vec;
    logic [1:0]      start_idx;
    logic [1:0]      sel_idx;
    logic            has_slot;
    logic            push;
    logic            pop;

    assign empty_vec = {~bus.din_3.vld, ~bus.din_2.vld,
                        ~bus.din_1.vld, ~bus.din_0.vld};

`ifdef SIDEBUF_ROTATE_EN
    logic [1:0] last_slot;

    assign start_idx = last_slot + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_slot <= 2'd3;
        end else if (pop) begin
            last_slot <= sel_idx;
        end
    end
`else
    assign start_idx = 2'd0;
`endif

    // Walk backwards so the first free slot from start_idx wins.
    always_comb begin
        sel_idx  = start_idx;
        has_slot = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (empty_vec[start_idx + 2'(i)]) begin
                sel_idx  = start_idx + 2'(i);
                has_slot = 1'b1;
            end
        end
    end

    // A grant cycle frees the redirected flit's own slot, so never reinject then.
    assign push     = bus.redirect_gnt && (count != CNT_FULL);
    assign pop      = (count != '0) && !bus.redirect_gnt && has_slot;
    assign chnl_vec = pop ? chnl_onehot(sel_idx) : 4'b0000;
    assign count_n  = count + CW'(push) - CW'(pop);

    always_comb begin
        stv_cnt_n = stv_cnt;
        if ((count == '0) || pop) begin
            stv_cnt_n = 8'd0;
        end else if (stv_cnt != TH) begin
            stv_cnt_n = stv_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            stv_cnt  <= 8'd0;
            full_q   <= 1'b0;
            starve_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_n;
            stv_cnt  <= stv_cnt_n;
            full_q   <= (count_n == CNT_FULL);
            starve_q <= (stv_cnt_n == TH);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= bus.din_redirected;
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(bus.redirect_gnt && (count == CNT_FULL)));

    insert_one_flit u_ins (
        .din_0    (bus.din_0),
        .din_1    (bus.din_1),
        .din_2    (bus.din_2),
        .din_3    (bus.din_3),
        .ins_flit (mem[rd_ptr]),
        .chnl_vec (chnl_vec),
        .dout_0   (bus.dout_0),
        .dout_1   (bus.dout_1),
        .dout_2   (bus.dout_2),
        .dout_3   (bus.dout_3)
    );

    assign bus.full   = full_q;
    assign bus.starve = starve_q;

endmodule
